// File: rtl/img_rsz_comp_eng_gen.sv
// Image resizer compute engine.
// Averages each gathered pixel block per channel by dividing the block sums by the block size.
// The block size (Hor*Ver) is built up by repeated addition after ImgStart.
// One restoring divider per channel shares a single control FSM.
// The divider produces one quotient bit per cycle, MSB first.
// Optional feature macro: IMG_RSZ_CE_ROUND_EN. When defined, half the block size is added to
// every sum before division, so the average rounds half-up instead of truncating.
module img_rsz_comp_eng_gen #(
  parameter int CH_NUM    = 3,
  parameter int PXL_W     = 8,
  parameter int BLK_HOR_W = 4,
  parameter int BLK_VER_W = 4,
  parameter int POS_X_W   = 10,
  parameter int POS_Y_W   = 10
) (
  input  logic                                        Clk,
  input  logic                                        Reset,
  input  logic                                        ImgStart,
  input  logic [BLK_HOR_W-1:0]                        BlkSzHor,
  input  logic [BLK_VER_W-1:0]                        BlkSzVer,
  input  logic                                        RszImgComp,
  input  logic [CH_NUM*(PXL_W+BLK_HOR_W+BLK_VER_W)-1:0] CompBlkData,
  input  logic [POS_X_W-1:0]                          CompBlkXPos,
  input  logic [POS_Y_W-1:0]                          CompBlkYPos,
  input  logic                                        CompBlkVld,
  output logic                                        CompBlkRdy,
  output logic [CH_NUM*PXL_W-1:0]                     CeRszPxlData,
  output logic [POS_X_W-1:0]                          CeRszPxlXPos,
  output logic [POS_Y_W-1:0]                          CeRszPxlYPos,
  output logic                                        CeCompVld,
  input  logic                                        CeCompRdy,
  output logic [BLK_HOR_W+BLK_VER_W-1:0]              ProcBlkSz,
  output logic                                        CompEngRdy
);

  localparam int BLK_SZ_W = BLK_HOR_W + BLK_VER_W;
  localparam int SUM_W    = PXL_W + BLK_SZ_W;
`ifdef IMG_RSZ_CE_ROUND_EN
  localparam int NUM_W    = SUM_W + 1;
`else
  localparam int NUM_W    = SUM_W;
`endif
  localparam int CNT_W    = $clog2(PXL_W);

  localparam logic [1:0] SZ_IDLE = 2'd0;
  localparam logic [1:0] SZ_ACC  = 2'd1;
  localparam logic [1:0] SZ_DONE = 2'd2;

  localparam logic [1:0] DP_IDLE = 2'd0;
  localparam logic [1:0] DP_DIV  = 2'd1;
  localparam logic [1:0] DP_OUT  = 2'd2;

  logic [1:0]           sz_state;
  logic [1:0]           dp_state;
  logic [BLK_HOR_W-1:0] hor_l;
  logic [BLK_VER_W-1:0] ver_l;
  logic [BLK_VER_W-1:0] acc_cnt;
  logic                 comp_pend;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 blk_hs;

  logic [NUM_W-1:0]          num_in   [CH_NUM];
  logic [BLK_SZ_W-1:0]       rem_p0   [CH_NUM];
  logic [PXL_W-1:0]          quo_p0   [CH_NUM];
  logic                      sat_p0   [CH_NUM];
  logic [BLK_SZ_W-1:0]       div_p0;
  logic [BLK_SZ_W+PXL_W-1:0] step_nxt [CH_NUM];

`ifdef IMG_RSZ_CE_ROUND_EN
  // Bias the sum by half the divisor so the truncating divider rounds half-up.
  function automatic logic [NUM_W-1:0] f_round(input logic [SUM_W-1:0] sum,
                                               input logic [BLK_SZ_W-1:0] sz);
    return {1'b0, sum} + NUM_W'(sz >> 1);
  endfunction
`endif

  // The quotient cannot fit in PXL_W bits once the numerator reaches sz * 2^PXL_W.
  function automatic logic f_ovf(input logic [NUM_W-1:0] num,
                                 input logic [BLK_SZ_W-1:0] sz);
    logic [NUM_W:0] lim;
    lim = (NUM_W+1)'({sz, {PXL_W{1'b0}}});
    return {1'b0, num} >= lim;
  endfunction

  function automatic logic [PXL_W-1:0] f_sat(input logic [PXL_W-1:0] quo, input logic sat);
    return sat ? {PXL_W{1'b1}} : quo;
  endfunction

  // One restoring step: shift the next numerator bit into the remainder.
  // Subtract the divisor if it fits, and shift the resulting quotient bit into the low end.
  // The remainder stays below the divisor, so it always fits in BLK_SZ_W bits.
  function automatic logic [BLK_SZ_W+PXL_W-1:0] f_div_step(input logic [BLK_SZ_W-1:0] rem,
                                                           input logic [PXL_W-1:0]    quo,
                                                           input logic [BLK_SZ_W-1:0] dvs);
    logic [BLK_SZ_W:0]   trial;
    logic [BLK_SZ_W-1:0] diff;
    logic                qbit;
    trial = {rem, quo[PXL_W-1]};
    diff  = trial[BLK_SZ_W-1:0] - dvs;
    qbit  = (trial >= {1'b0, dvs});
    return {(qbit ? diff : trial[BLK_SZ_W-1:0]), quo[PXL_W-2:0], qbit};
  endfunction

  assign CompEngRdy = (sz_state == SZ_DONE);
  assign CompBlkRdy = CompEngRdy & (dp_state == DP_IDLE);
  assign CeCompVld  = (dp_state == DP_OUT);
  assign blk_hs     = CompBlkVld & CompBlkRdy;

  // Numerator per channel as presented at the input handshake.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
`ifdef IMG_RSZ_CE_ROUND_EN
      num_in[c] = f_round(CompBlkData[c*SUM_W +: SUM_W], ProcBlkSz);
`else
      num_in[c] = CompBlkData[c*SUM_W +: SUM_W];
`endif
    end
  end

  // Next divider state for every channel.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      step_nxt[c] = f_div_step(rem_p0[c], quo_p0[c], div_p0);
    end
  end

  // Block-size FSM: accumulate Hor Ver times, then hold the size until the image completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sz_state  <= SZ_IDLE;
      ProcBlkSz <= '0;
      acc_cnt   <= '0;
      hor_l     <= '0;
      ver_l     <= '0;
      comp_pend <= 1'b0;
    end else begin
      case (sz_state)
        SZ_IDLE: begin
          comp_pend <= 1'b0;
          if (ImgStart) begin
            hor_l     <= (BlkSzHor == '0) ? BLK_HOR_W'(1) : BlkSzHor;
            ver_l     <= (BlkSzVer == '0) ? BLK_VER_W'(1) : BlkSzVer;
            ProcBlkSz <= '0;
            acc_cnt   <= '0;
            sz_state  <= SZ_ACC;
          end
        end
        SZ_ACC: begin
          ProcBlkSz <= ProcBlkSz + BLK_SZ_W'(hor_l);
          acc_cnt   <= acc_cnt + BLK_VER_W'(1);
          if (acc_cnt == ver_l - BLK_VER_W'(1)) sz_state <= SZ_DONE;
        end
        SZ_DONE: begin
          // A completion request waits for the datapath to drain before the size is released.
          if ((RszImgComp || comp_pend) && (dp_state == DP_IDLE)) begin
            comp_pend <= 1'b0;
            sz_state  <= SZ_IDLE;
          end else if (RszImgComp) begin
            comp_pend <= 1'b1;
          end
        end
        default: sz_state <= SZ_IDLE;
      endcase
    end
  end

  // Datapath control and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dp_state     <= DP_IDLE;
      bit_cnt      <= '0;
      CeRszPxlData <= '0;
      CeRszPxlXPos <= '0;
      CeRszPxlYPos <= '0;
    end else begin
      case (dp_state)
        DP_IDLE: begin
          if (blk_hs) begin
            CeRszPxlXPos <= CompBlkXPos;
            CeRszPxlYPos <= CompBlkYPos;
            bit_cnt      <= '0;
            dp_state     <= DP_DIV;
          end
        end
        DP_DIV: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(PXL_W-1)) begin
            for (int c = 0; c < CH_NUM; c++) begin
              CeRszPxlData[c*PXL_W +: PXL_W] <= f_sat(step_nxt[c][PXL_W-1:0], sat_p0[c]);
            end
            dp_state <= DP_OUT;
          end
        end
        DP_OUT: begin
          if (CeCompRdy) dp_state <= DP_IDLE;
        end
        default: dp_state <= DP_IDLE;
      endcase
    end
  end

  // ---- p0: operands latched at the input handshake, then iterated by the divider ----
  always_ff @(posedge Clk) begin
    if (dp_state == DP_IDLE && blk_hs) begin
      div_p0 <= ProcBlkSz;
      for (int c = 0; c < CH_NUM; c++) begin
        rem_p0[c] <= num_in[c][PXL_W +: BLK_SZ_W];
        quo_p0[c] <= num_in[c][PXL_W-1:0];
        sat_p0[c] <= f_ovf(num_in[c], ProcBlkSz);
      end
    end else if (dp_state == DP_DIV) begin
      for (int c = 0; c < CH_NUM; c++) begin
        {rem_p0[c], quo_p0[c]} <= step_nxt[c];
      end
    end
  end

endmodule
